fft16_seq: RTL
==============

# fft16_seq

Sequencer that drives the shared radix-4 `butterfly` core through a complete 16-point FFT. It accepts 16 complex samples on a valid/ready stream and buffers them. It then issues four stage-1 butterfly operations (rotation 0–3), captures and transposes their results, and issues four stage-2 operations (rotation 4–7). The 16 spectrum bins leave on a valid/ready output stream. It sits between the sample front-end and the output formatter, and owns the butterfly's `calc_in`/`rotation` inputs.

## Interface
Parameters:
- `BF_LATENCY`, default 1: clock cycles from `bf_calc_in`/`bf_rotation` to the matching `bf_calc_out`, with a legal range of 1–4.

Ports:
- `clk`, input, 1: single clock; all logic is rising-edge.
- `rst_n`, input, 1: reset, synchronous and active-low.
- `in_valid`, input, 1: input sample valid.
- `in_ready`, output, 1: block accepts a sample.
- `in_data`, input, 34: sample as {Re[16:0], Im[16:0]}. Each part is 2's complement: 1 sign bit, 8 integer bits, 8 fraction bits.
- `out_valid`, output, 1: output bin valid.
- `out_ready`, input, 1: downstream accepts a bin.
- `out_data`, output, 34: bin as {Re, Im}, same format as `in_data`.
- `out_index`, output, 4: bin number k of `out_data`.
- `bf_calc_in`, output, 136: to the butterfly `calc_in`. Slot0 = [135:102], slot1 = [101:68], slot2 = [67:34], slot3 = [33:0]. Each slot is {Re, Im}.
- `bf_rotation`, output, 3: to the butterfly `rotation`.
- `bf_calc_out`, input, 136: from the butterfly `calc_out`, same slot layout.
- `busy`, output, 1: high in every state except LOAD.

## Operation
- Storage: the input buffer `X[0..15]`, the stage-1 result buffer `S[0..3][0..3]`, and the result buffer `Y[0..15]`. All are 34-bit registers.
- **LOAD**
  - `in_ready` = 1.
  - Each `in_valid && in_ready` cycle writes `X[wcnt]` and increments `wcnt`.
  - Reaching 16 samples moves to ST1 and clears `wcnt`.
- **ST1**, for g = 0..3 on consecutive cycles:
  - `bf_calc_in` slot s = `X[4g+s]`.
  - `bf_rotation` = g.
  - Then move to DR1.
- Capture: a `BF_LATENCY`-deep shift register carries {valid, op number}.
  - When valid emerges for stage-1 op g: `S[g][s]` ← `bf_calc_out` slot s.
  - When valid emerges for stage-2 op k: `Y[k+4m]` ← `bf_calc_out` slot m.
- **DR1**: wait until all 4 stage-1 captures are done, then move to ST2.
- **ST2**, for k = 0..3 on consecutive cycles:
  - `bf_calc_in` slot m = `S[m][k]` (transpose).
  - `bf_rotation` = 4+k.
  - Then move to DR2.
- **DR2**: wait until all 4 stage-2 captures are done, then move to UNLOAD.
- **UNLOAD**
  - Present bin number j = `ocnt`'s mapped value; emission order is set under Configuration.
  - `out_data` = `Y[j]`, `out_index` = j, `out_valid` = 1.
  - Advance `ocnt` on `out_valid && out_ready`.
  - After the 16th transfer, return to LOAD.
- Arithmetic: none. Values pass through unmodified; scaling and saturation belong to the butterfly.
- `bf_calc_in` and `bf_rotation` are 0 in all states other than ST1 and ST2.

## Timing
- Reset values:
  - state = LOAD; counters = 0.
  - `in_ready` = 0 in the reset cycle and 1 from the first cycle after reset release.
  - `out_valid` = 0, `out_data` = 0, `out_index` = 0.
  - `bf_calc_in` = 0, `bf_rotation` = 0, `busy` = 0.
  - Buffers are not reset.
- `bf_*` outputs are registered; op g appears on the cycle after the state or counter update.
- Latency from 16th sample accepted to first `out_valid` is `2*(4+BF_LATENCY)+2` cycles, i.e. 12 with `BF_LATENCY`=1.
- Full throughput: 16 load + compute + 16 unload cycles. Load and unload do not overlap.
- Stalls:
  - A gap in `in_valid` stalls LOAD without losing the count.
  - `out_ready`=0 holds `out_data`/`out_index` stable while `out_valid` stays 1.
- Reset asserted in any state aborts the frame on that edge. All outputs return to reset values and in-flight butterfly results are discarded, because the latency pipe is cleared.
- `in_valid` during a busy state is ignored, since `in_ready`=0.

## Configuration
- Macro: `FFT16_SEQ_NATURAL_ORDER_EN`.
- Defined: bins are emitted in natural order, j = `ocnt` (0, 1, 2, …, 15).
- Undefined: bins are emitted in butterfly order, j = 4·(`ocnt` mod 4) + `ocnt`/4 (0, 4, 8, 12, 1, 5, …, 15). This saves the output reorder mux.
- `out_index` always carries the true bin number.

## Test plan
- **Identity stub** (butterfly passes through, `BF_LATENCY`=1), inputs `X[n]` = {n<<8, 0}:
  - Stage-1 op 1 shows slots {4.0, 5.0, 6.0, 7.0} with rotation 1.
  - Stage-2 op 1 shows {1.0, 5.0, 9.0, 13.0} with rotation 5.
  - Each output has `out_data` Re = `out_index`<<8.
- **Real butterfly**, impulse `X[0]` = 17'h00100 (1.0), rest 0:
  - All 16 bins have Re = 1.0 (17'h00100), Im = 0.
  - Checked in both macro settings.
- **`BF_LATENCY`=3**, same identity run:
  - First `out_valid` appears 16 cycles after the 16th input, and bins are correct.
- **Backpressure**: `out_ready` toggled 1,0,0,1 and `in_valid` with random gaps.
  - No bin is lost or duplicated.
  - `out_data` is stable while stalled.
  - `in_ready` = 0 throughout compute and unload.
- **Mid-frame reset**: `rst_n`=0 for 1 cycle during ST2.
  - Next cycle: `out_valid`=0, `bf_calc_in`=0, `busy`=0.
  - A following full frame produces correct bins with no stale captures.
- **Order check** with `FFT16_SEQ_NATURAL_ORDER_EN` undefined:
  - `out_index` sequence is 0, 4, 8, 12, 1, …, 15.

Source files
------------

// File: rtl/fft16_seq.sv
// fft16_seq: buffers 16 complex samples and runs two radix-4 passes through an external butterfly.
// Optional macro FFT16_SEQ_NATURAL_ORDER_EN emits bins in natural order instead of butterfly order.
module fft16_seq #(
   parameter int BF_LATENCY = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [33:0]  in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [33:0]  out_data,
   output logic [3:0]   out_index,
   output logic [135:0] bf_calc_in,
   output logic [2:0]   bf_rotation,
   input  logic [135:0] bf_calc_out,
   output logic         busy
);
   typedef enum logic [2:0] {LOAD, ST1, DR1, ST2, DR2, UNLOAD} state_t;

   state_t              r_state, w_state_nxt;
   logic [33:0]         r_x [16];
   logic [33:0]         r_s [4][4];
   logic [33:0]         r_y [16];
   logic [3:0]          r_wcnt, r_ocnt;
   logic [1:0]          r_opcnt;
   logic                r_in_ready;
   logic [135:0]        r_bf_calc_in;
   logic [2:0]          r_bf_rot;
   logic [BF_LATENCY:0] r_vld_pipe;
   logic [2:0]          r_op_pipe [BF_LATENCY+1];

   logic                w_in_fire, w_out_fire, w_issue, w_cap;
   logic [2:0]          w_cap_op;
   logic [3:0]          w_j;
   logic [3:0][33:0]    w_slot;
   logic [135:0]        w_calc_nxt;
   logic [2:0]          w_rot_nxt;

   genvar gs;
   generate
      for (gs = 0; gs < 4; gs++) begin : g_slot
         assign w_slot[gs] = bf_calc_out[135-34*gs -: 34];
      end
   endgenerate

   assign w_in_fire  = in_valid && r_in_ready;
   assign w_out_fire = out_valid && out_ready;
   assign w_issue    = (r_state == ST1) || (r_state == ST2);
   // Stage 0 of the pipe is aligned with the registered bf_* outputs.
   assign w_cap      = r_vld_pipe[BF_LATENCY];
   assign w_cap_op   = r_op_pipe[BF_LATENCY];

`ifdef FFT16_SEQ_NATURAL_ORDER_EN
   assign w_j = r_ocnt;
`else
   assign w_j = {r_ocnt[1:0], r_ocnt[3:2]};
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= LOAD;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         LOAD:    if (w_in_fire && r_wcnt == 4'd15)       w_state_nxt = ST1;
         ST1:     if (r_opcnt == 2'd3)                    w_state_nxt = DR1;
         DR1:     if (w_cap && w_cap_op == 3'd3)          w_state_nxt = ST2;
         ST2:     if (r_opcnt == 2'd3)                    w_state_nxt = DR2;
         DR2:     if (w_cap && w_cap_op == 3'd7)          w_state_nxt = UNLOAD;
         UNLOAD:  if (w_out_fire && r_ocnt == 4'd15)      w_state_nxt = LOAD;
         default: w_state_nxt = LOAD;
      endcase
   end

   // Stage 2 reads the stage-1 results transposed: slot m of op k is S[m][k].
   always_comb begin
      w_calc_nxt = '0;
      w_rot_nxt  = '0;
      for (int s = 0; s < 4; s++) begin
         if (r_state == ST1)      w_calc_nxt[135-34*s -: 34] = r_x[{r_opcnt, 2'(s)}];
         else if (r_state == ST2) w_calc_nxt[135-34*s -: 34] = r_s[s][r_opcnt];
      end
      if (r_state == ST1)      w_rot_nxt = {1'b0, r_opcnt};
      else if (r_state == ST2) w_rot_nxt = {1'b1, r_opcnt};
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wcnt       <= '0;
         r_ocnt       <= '0;
         r_opcnt      <= '0;
         r_in_ready   <= 1'b0;
         r_bf_calc_in <= '0;
         r_bf_rot     <= '0;
         r_vld_pipe   <= '0;
         for (int i = 0; i <= BF_LATENCY; i++) r_op_pipe[i] <= '0;
      end else begin
         r_in_ready   <= (w_state_nxt == LOAD);
         if (w_in_fire)  r_wcnt <= r_wcnt + 4'd1;
         if (w_out_fire) r_ocnt <= r_ocnt + 4'd1;
         r_opcnt      <= w_issue ? r_opcnt + 2'd1 : 2'd0;
         r_bf_calc_in <= w_calc_nxt;
         r_bf_rot     <= w_rot_nxt;
         r_vld_pipe   <= {r_vld_pipe[BF_LATENCY-1:0], w_issue};
         r_op_pipe[0] <= w_rot_nxt;
         for (int i = 1; i <= BF_LATENCY; i++) r_op_pipe[i] <= r_op_pipe[i-1];
      end
   end

   // Sample and result buffers carry no reset; writes are suppressed while reset is held.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         if (w_in_fire) r_x[r_wcnt] <= in_data;
         if (w_cap) begin
            for (int s = 0; s < 4; s++) begin
               if (w_cap_op[2]) r_y[{2'(s), w_cap_op[1:0]}] <= w_slot[s];
               else             r_s[w_cap_op[1:0]][s]       <= w_slot[s];
            end
         end
      end
   end

   assign in_ready    = r_in_ready;
   assign out_valid   = (r_state == UNLOAD);
   assign out_data    = out_valid ? r_y[w_j] : '0;
   assign out_index   = out_valid ? w_j : '0;
   assign bf_calc_in  = r_bf_calc_in;
   assign bf_rotation = r_bf_rot;
   assign busy        = (r_state != LOAD);

endmodule
